// File: rtl/jt6295_pkg.sv
// jt6295_pkg: shared tables and constants for the jt6295 ADPCM generator.
// Holds the OKI step table, index-adjust table, attenuation multipliers,
// phrase-table stride and the two sample-period lengths.
package jt6295_pkg;

    // Each phrase-table entry is 8 bytes; entry n lives at n*8
    localparam logic [17:0] PHRASE_STRIDE = 18'd8;

    // Sample period in cen ticks for each ss setting
    localparam logic [7:0] PERIOD_SS1 = 8'd132;
    localparam logic [7:0] PERIOD_SS0 = 8'd165;

    // OKI/Dialogic ADPCM step sizes, indexed 0..48
    localparam logic [10:0] STEP_TABLE [49] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
        11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
        11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
        11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
        11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
        11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
        11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
    };

    // Step-index adjustment by nibble magnitude (bits 2:0)
    localparam logic signed [4:0] IDX_ADJ [8] = '{
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
    };

    // Attenuation multiplier (out of 32) per 4-bit attenuation code
    localparam logic [5:0] ATT_MUL [16] = '{
        6'd32, 6'd23, 6'd16, 6'd11, 6'd8, 6'd6, 6'd4, 6'd3,
        6'd2,  6'd0,  6'd0,  6'd0,  6'd0, 6'd0, 6'd0, 6'd0
    };

    // CPU command decoder: waiting for a command, or for the voice/att byte
    typedef enum logic {
        CMD_IDLE,
        CMD_PEND
    } cmd_state_t;

    // Shared ROM fetch engine
    typedef enum logic [1:0] {
        F_IDLE,
        F_TBL,
        F_DATA
    } fetch_state_t;

endpackage

// File: rtl/jt6295_adpcm.sv
// jt6295_adpcm: one OKI ADPCM decode step for a single voice.
// Purely combinational; the top time-multiplexes it across the four voices.
module jt6295_adpcm
    import jt6295_pkg::*;
(
    input  logic        [3:0]  nibble,
    input  logic signed [11:0] sig_in,
    input  logic        [5:0]  idx_in,
    output logic signed [11:0] sig_out,
    output logic        [5:0]  idx_out
);

    logic        [10:0] step;
    logic        [12:0] diff;
    logic signed [13:0] sum;
    logic signed [4:0]  adj;
    logic signed [7:0]  idx_sum;

    // Build diff = step*(2*mag+1)/8 from shifted steps, apply sign, saturate,
    // then move the step index and clamp it to the table range.
    always_comb begin
        // NOTE: blocking assignments here because each line builds on the
        // previous one within the same evaluation; sequential state never does.
        step = STEP_TABLE[(idx_in > 6'd48) ? 6'd48 : idx_in];
        diff = 13'(step >> 3);
        if (nibble[2]) diff = diff + 13'(step);
        if (nibble[1]) diff = diff + 13'(step >> 1);
        if (nibble[0]) diff = diff + 13'(step >> 2);

        if (nibble[3]) sum = {{2{sig_in[11]}}, sig_in} - {1'b0, diff};
        else           sum = {{2{sig_in[11]}}, sig_in} + {1'b0, diff};

        if (sum > 14'sd2047)       sig_out = 12'sd2047;
        else if (sum < -14'sd2048) sig_out = -12'sd2048;
        else                       sig_out = sum[11:0];

        adj     = IDX_ADJ[nibble[2:0]];
        idx_sum = $signed({2'b00, idx_in}) + $signed({{3{adj[4]}}, adj});
        if (idx_sum < 8'sd0)       idx_out = 6'd0;
        else if (idx_sum > 8'sd48) idx_out = 6'd48;
        else                       idx_out = idx_sum[5:0];
    end

endmodule

// File: rtl/jt6295.sv
// jt6295: four-voice OKI MSM6295-compatible ADPCM sound generator.
// One shared ROM fetch engine serves phrase-table and sample reads
// round-robin; one ADPCM decoder is time-multiplexed over the voices once
// per sample period. Define JT6295_ATT_EN to apply per-voice attenuation;
// without it the attenuation code is latched but every voice plays at 32/32.
module jt6295
    import jt6295_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               ss,
    input  logic               wrn,
    input  logic        [7:0]  din,
    output logic        [7:0]  dout,
    output logic        [17:0] rom_addr,
    input  logic        [7:0]  rom_data,
    input  logic               rom_ok,
    output logic signed [13:0] sound
);

    // Per-voice state
    logic        [3:0]  busy, need_tbl, need_data, byte_valid, nib_low;
    logic signed [11:0] signal   [4];
    logic        [5:0]  index    [4];
    logic        [17:0] addr     [4];
    logic        [17:0] end_addr [4];
    logic        [7:0]  data     [4];
    logic        [6:0]  phrase_v [4];
    logic        [3:0]  att      [4];

    // CPU side
    cmd_state_t   cmd_st;
    logic [6:0]   phrase;
    logic         wrn_l;
    logic         we;

    // Fetch engine
    fetch_state_t fst;
    logic [1:0]   cur_v, rr, sel_v, cand;
    logic         sel_ok, ok_seen, kill;
    logic [2:0]   tbl_cnt;
    logic [17:0]  st_buf;
    logic [9:0]   en_hi;

    // Sample timing and decode sequencing
    logic [7:0]   div_cnt;
    logic         tick;
    logic         dec_run;
    logic [2:0]   dec_step;
    logic [1:0]   dv;
    logic         dec_live;
    logic [3:0]   dec_nib;
    logic signed [11:0] dec_sig, voice_sig, v_out;
    logic        [5:0]  dec_idx;
    logic signed [13:0] acc;

    assign dout = {4'hF, busy};
    assign we   = wrn_l & ~wrn;
    assign tick = cen && (div_cnt == 8'd0);

    // Sample-period divider; ss is picked up each time a period begins
    always_ff @(posedge clk) begin
        if (rst)       div_cnt <= 8'd0;
        else if (cen)  div_cnt <= (div_cnt == 8'd0) ? (ss ? PERIOD_SS1 - 8'd1 : PERIOD_SS0 - 8'd1)
                                                    : div_cnt - 8'd1;
    end

    // Round-robin pick of the next voice wanting a table or data read
    always_comb begin
        sel_ok = 1'b0;
        sel_v  = rr;
        cand   = rr;
        for (int i = 3; i >= 0; i--) begin
            cand = rr + 2'(i);
            if (need_tbl[cand] | need_data[cand]) begin
                sel_ok = 1'b1;
                sel_v  = cand;
            end
        end
    end

    // Operands for the voice currently being decoded
    always_comb begin
        dv        = dec_step[1:0];
        dec_live  = busy[dv] & byte_valid[dv];
        dec_nib   = nib_low[dv] ? data[dv][3:0] : data[dv][7:4];
        voice_sig = dec_live ? dec_sig : (busy[dv] ? signal[dv] : 12'sd0);
    end

    jt6295_adpcm u_adpcm (
        .nibble  (dec_nib),
        .sig_in  (signal[dv]),
        .idx_in  (index[dv]),
        .sig_out (dec_sig),
        .idx_out (dec_idx)
    );

`ifdef JT6295_ATT_EN
    logic signed [6:0]  att_m;
    logic signed [16:0] att_prod;

    // Scale the voice by its attenuation multiplier (m/32)
    always_comb begin
        att_m    = $signed({1'b0, ATT_MUL[att[dv]]});
        att_prod = voice_sig * att_m;
        v_out    = 12'(att_prod >>> 5);
    end
`else
    logic att_unused;
    assign att_unused = ^{att[0], att[1], att[2], att[3]};

    // Full volume: (signal*32)>>>5 is the signal itself
    always_comb begin
        v_out = voice_sig;
    end
`endif

    // Write-strobe edge detector
    always_ff @(posedge clk) begin
        if (rst) wrn_l <= 1'b1;
        else     wrn_l <= wrn;
    end

    // Voice state, ROM fetch engine, decode sequencer and CPU commands.
    // Later sections override earlier ones, so a CPU stop always wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the per-voice register arrays are small flops, not RAM,
            // so they are cleared on reset like any other state.
            for (int i = 0; i < 4; i++) begin
                signal[i]   <= 12'sd0;
                index[i]    <= 6'd0;
                addr[i]     <= 18'd0;
                end_addr[i] <= 18'd0;
                data[i]     <= 8'd0;
                phrase_v[i] <= 7'd0;
                att[i]      <= 4'd0;
            end
            busy       <= 4'd0;
            need_tbl   <= 4'd0;
            need_data  <= 4'd0;
            byte_valid <= 4'd0;
            nib_low    <= 4'd0;
            cmd_st     <= CMD_IDLE;
            phrase     <= 7'd0;
            fst        <= F_IDLE;
            cur_v      <= 2'd0;
            rr         <= 2'd0;
            ok_seen    <= 1'b0;
            kill       <= 1'b0;
            tbl_cnt    <= 3'd0;
            st_buf     <= 18'd0;
            en_hi      <= 10'd0;
            rom_addr   <= 18'd0;
            dec_run    <= 1'b0;
            dec_step   <= 3'd0;
            acc        <= 14'sd0;
            sound      <= 14'sd0;
        end else begin
            // ROM fetch: address out, wait for rom_ok, capture on next edge
            case (fst)
                F_IDLE: if (sel_ok) begin
                    cur_v   <= sel_v;
                    rr      <= sel_v + 2'd1;
                    ok_seen <= 1'b0;
                    kill    <= 1'b0;
                    if (need_tbl[sel_v]) begin
                        need_tbl[sel_v] <= 1'b0;
                        tbl_cnt         <= 3'd0;
                        rom_addr        <= 18'(phrase_v[sel_v]) * PHRASE_STRIDE;
                        fst             <= F_TBL;
                    end else begin
                        need_data[sel_v] <= 1'b0;
                        rom_addr         <= addr[sel_v];
                        fst              <= F_DATA;
                    end
                end
                F_TBL: if (!ok_seen) begin
                    ok_seen <= rom_ok;
                end else begin
                    ok_seen <= 1'b0;
                    case (tbl_cnt)
                        3'd0:    st_buf[17:16] <= rom_data[1:0];
                        3'd1:    st_buf[15:8]  <= rom_data;
                        3'd2:    st_buf[7:0]   <= rom_data;
                        3'd3:    en_hi[9:8]    <= rom_data[1:0];
                        3'd4:    en_hi[7:0]    <= rom_data;
                        default: ;
                    endcase
                    if (tbl_cnt == 3'd5) begin
                        fst <= F_IDLE;
                        if (!kill) begin
                            if (st_buf > {en_hi, rom_data}) begin
                                busy[cur_v] <= 1'b0;
                            end else begin
                                addr[cur_v]      <= st_buf;
                                end_addr[cur_v]  <= {en_hi, rom_data};
                                need_data[cur_v] <= 1'b1;
                            end
                        end
                    end else begin
                        tbl_cnt  <= tbl_cnt + 3'd1;
                        rom_addr <= rom_addr + 18'd1;
                    end
                end
                F_DATA: if (!ok_seen) begin
                    ok_seen <= rom_ok;
                end else begin
                    ok_seen <= 1'b0;
                    fst     <= F_IDLE;
                    if (!kill) begin
                        data[cur_v]       <= rom_data;
                        byte_valid[cur_v] <= 1'b1;
                        nib_low[cur_v]    <= 1'b0;
                    end
                end
                default: fst <= F_IDLE;
            endcase

            // Decode: one voice per clk after the period tick, then publish mix
            if (tick) begin
                dec_run  <= 1'b1;
                dec_step <= 3'd0;
                acc      <= 14'sd0;
            end else if (dec_run) begin
                if (dec_step == 3'd4) begin
                    sound   <= acc;
                    dec_run <= 1'b0;
                end else begin
                    acc      <= acc + {{2{v_out[11]}}, v_out};
                    dec_step <= dec_step + 3'd1;
                    if (dec_live) begin
                        signal[dv] <= dec_sig;
                        index[dv]  <= dec_idx;
                        if (nib_low[dv]) begin
                            nib_low[dv]    <= 1'b0;
                            byte_valid[dv] <= 1'b0;
                            if (addr[dv] == end_addr[dv]) begin
                                busy[dv]   <= 1'b0;
                                signal[dv] <= 12'sd0;
                                index[dv]  <= 6'd0;
                            end else begin
                                addr[dv]      <= addr[dv] + 18'd1;
                                need_data[dv] <= 1'b1;
                            end
                        end else begin
                            nib_low[dv] <= 1'b1;
                        end
                    end
                end
            end

            // CPU commands
            if (we) begin
                case (cmd_st)
                    CMD_IDLE: begin
                        if (din[7]) begin
                            phrase <= din[6:0];
                            cmd_st <= CMD_PEND;
                        end else begin
                            for (int i = 0; i < 4; i++) begin
                                if (din[3+i]) begin
                                    busy[i]       <= 1'b0;
                                    need_tbl[i]   <= 1'b0;
                                    need_data[i]  <= 1'b0;
                                    byte_valid[i] <= 1'b0;
                                    nib_low[i]    <= 1'b0;
                                    signal[i]     <= 12'sd0;
                                    index[i]      <= 6'd0;
                                    // Drop any read already in flight for this voice
                                    if ((fst != F_IDLE && cur_v == 2'(i)) ||
                                        (fst == F_IDLE && sel_ok && sel_v == 2'(i)))
                                        kill <= 1'b1;
                                end
                            end
                        end
                    end
                    CMD_PEND: begin
                        cmd_st <= CMD_IDLE;
                        if (phrase != 7'd0) begin
                            for (int i = 0; i < 4; i++) begin
                                if (din[4+i] && !busy[i]) begin
                                    busy[i]       <= 1'b1;
                                    need_tbl[i]   <= 1'b1;
                                    need_data[i]  <= 1'b0;
                                    byte_valid[i] <= 1'b0;
                                    nib_low[i]    <= 1'b0;
                                    signal[i]     <= 12'sd0;
                                    index[i]      <= 6'd0;
                                    phrase_v[i]   <= phrase;
                                    att[i]        <= din[3:0];
                                end
                            end
                        end
                    end
                    default: cmd_st <= CMD_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jt6295.sv
// tb_jt6295: directed self-checking bench for jt6295.
// ROM model answers after one settle cycle; cen runs at clk/2.
module tb_jt6295;

    logic               clk = 1'b0;
    logic               rst, cen = 1'b0, ss, wrn;
    logic        [7:0]  din, dout, rom_data;
    logic        [17:0] rom_addr;
    logic               rom_ok;
    logic signed [13:0] sound;

    logic [7:0]  rom [0:262143];
    logic [17:0] last_addr;
    logic [17:0] log_prev = 18'd0;
    logic [17:0] addr_log [$];

    int checks = 0;
    int errors = 0;

    localparam int WAIT_LIMIT = 2000;

    jt6295 dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .ss       (ss),
        .wrn      (wrn),
        .din      (din),
        .dout     (dout),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .sound    (sound)
    );

    always #5 clk = ~clk;

    // cen at half the clk rate
    always @(posedge clk) cen <= ~cen;

    // ROM: data follows the address, ok once the address has been stable a clk
    assign rom_data = rom[rom_addr];
    always @(posedge clk) last_addr <= rom_addr;
    assign rom_ok = (rom_addr == last_addr);

    // Record every distinct address the DUT presents
    always @(posedge clk) begin
        if (!rst && rom_addr != log_prev) begin
            addr_log.push_back(rom_addr);
            log_prev <= rom_addr;
        end
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [7:0] d);
        @(negedge clk);
        din = d;
        wrn = 1'b0;
        repeat (3) @(negedge clk);
        wrn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Wait for the next change of sound; returns new value and clks waited
    task automatic wait_sound(input string tag, output logic signed [13:0] v,
                              output int clks);
        logic signed [13:0] prev;
        prev = sound;
        clks = 0;
        while (sound === prev && clks < WAIT_LIMIT) begin
            @(negedge clk);
            clks++;
        end
        v = sound;
        check({tag, "_arrived"}, (clks < WAIT_LIMIT) ? 1 : 0, 1);
    endtask

    initial begin
        logic signed [13:0] v;
        int n;
        logic [17:0] exp_log [8];
        exp_log = '{18'h8, 18'h9, 18'hA, 18'hB, 18'hC, 18'hD, 18'h400, 18'h401};

        for (int i = 0; i < 262144; i++) rom[i] = 8'h00;
        // Phrase 1: start 0x000400, end 0x000401
        rom[8]  = 8'h00; rom[9]  = 8'h04; rom[10] = 8'h00;
        rom[11] = 8'h00; rom[12] = 8'h04; rom[13] = 8'h01;
        rom[18'h400] = 8'h78;
        rom[18'h401] = 8'h12;

        rst = 1'b1; wrn = 1'b1; din = 8'h00; ss = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_dout", dout, 8'hF0);
        check("rst_sound", sound, 0);
        check("rst_addr", rom_addr, 0);
        rst = 1'b0;

        // Idle: nothing fetched before the first command
        repeat (300) @(negedge clk);
        check("idle_addr", rom_addr, 0);
        check("idle_log", addr_log.size(), 0);
        check("idle_sound", sound, 0);

        // Single voice, phrase 1, att 0
        cpu_wr(8'h81);
        cpu_wr(8'h10);
        check("start_dout", dout, 8'hF1);
        // nib 7, step 16: 2+16+8+4 = 30, index 8
        wait_sound("s1", v, n); check("s1", v, 30);
        // nib 8, step 34: diff 4 -> 26, index 7
        wait_sound("s2", v, n); check("s2", v, 26);
        check("period_ss1", n, 264);
        // nib 1, step 31: 3+7 -> 36, index 6
        wait_sound("s3", v, n); check("s3", v, 36);
        // nib 2, step 28: 3+14 -> 53, index 5
        wait_sound("s4", v, n); check("s4", v, 53);
        wait_sound("s_end", v, n); check("s_end", v, 0);
        check("end_dout", dout, 8'hF0);
        check("log_len", addr_log.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("log_%0d", i), addr_log[i], exp_log[i]);

        // Attenuation code 2, then stop while busy
        cpu_wr(8'h81);
        cpu_wr(8'h12);
        wait_sound("att", v, n);
`ifdef JT6295_ATT_EN
        check("att2_s1", v, 15);   // (30*16)>>>5
`else
        check("att2_s1", v, 30);   // code ignored, m = 32
`endif
        check("att_dout", dout, 8'hF1);
        cpu_wr(8'h08);
        check("stop_dout", dout, 8'hF0);
        wait_sound("stop", v, n); check("stop_sound", v, 0);

        // Two voices, ss = 0
        ss = 1'b0;
        cpu_wr(8'h81);
        cpu_wr(8'h30);
        check("dual_dout", dout, 8'hF3);
        wait_sound("d1", v, n); check("d1", v, 60);
        wait_sound("d2", v, n); check("d2", v, 52);
        wait_sound("d3", v, n); check("d3", v, 72);
        check("period_ss0", n, 330);
        wait_sound("d4", v, n); check("d4", v, 106);
        wait_sound("d_end", v, n); check("d_end", v, 0);
        check("dual_end_dout", dout, 8'hF0);

        // Phrase 0 must not start anything
        cpu_wr(8'h80);
        cpu_wr(8'h10);
        check("phrase0_dout", dout, 8'hF0);

        // Reset during playback
        cpu_wr(8'h81);
        cpu_wr(8'h10);
        wait_sound("pre_rst", v, n); check("pre_rst", v, 30);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_dout", dout, 8'hF0);
        check("midrst_sound", sound, 0);
        check("midrst_addr", rom_addr, 0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
